aud_cic_agc: RTL and testbench
==============================

// Module: aud_cic_agc
// PURPOSE
//  Automatic gain controller for the audio CIC decimator. Monitors decimated CIC output samples,
//  measures windowed peak magnitude and drives the decimator's gain (output shift) input.
//  Sits beside the CIC: its in_tick/x_in come from the CIC out_tick/x_out; its gain feeds the CIC gain.
//  Supports manual gain override; clamps and steps gain, and holds off after every change.
// PARAMETERS
//  BITS        16  sample width (matches CIC BITS)
//  GAIN_BITS    8  gain port width (matches CIC GAIN_BITS)
//  GAIN_MAX    16  max gain code; must be <= CIC WIDTH-BITS-3 and < 2**GAIN_BITS
//  GAIN_INIT    8  gain after reset
//  WINDOW      64  samples per peak-measurement window (>=2)
//  SETTLE       8  samples discarded after any gain change (CIC comb transient)
//  HOLD_WIN     4  consecutive quiet windows required before gain increment (>=1)
//  ATTACK_STEP  2  gain decrement on clip
// PORTS
//  CLK       in   1          clock
//  RSTb      in   1          asynchronous active-low reset
//  agc_en    in   1          1 = automatic, 0 = manual
//  man_gain  in   GAIN_BITS  manual gain code
//  thr_hi    in   BITS-1     peak magnitude at/above which gain decrements
//  thr_lo    in   BITS-1     peak magnitude below which window counts as quiet
//  in_tick   in   1          1-cycle strobe, x_in valid
//  x_in      in   BITS       signed decimated sample
//  gain      out  GAIN_BITS  gain code to CIC (registered)
//  gain_upd  out  1          1-cycle pulse, asserted in the same cycle gain takes a new value
//  agc_state out  2          0 MANUAL, 1 SETTLE, 2 MEASURE, 3 DECIDE
//  clip_cnt  out  16         saturating clip counter (AUD_AGC_CLIP_CNT_EN only)
// BEHAVIOUR
//  Reset: gain=GAIN_INIT, gain_upd=0, agc_state=SETTLE, settle/window/quiet counters=0, peak=0, clip_cnt=0.
//  Magnitude: mag=|x_in| in BITS-1 bits; -2**(BITS-1) saturates to 2**(BITS-1)-1. clip = (mag==2**(BITS-1)-1).
//  MANUAL: entered the cycle after agc_en samples 0 (from any state, mid-window abandoned).
//   gain <= min(man_gain,GAIN_MAX) each cycle; gain_upd pulses on every cycle the value changes.
//   agc_en 0->1: go SETTLE, counters cleared, gain retained.
//  SETTLE: count in_ticks; on the SETTLE-th tick go MEASURE with peak=0, win_cnt=0, clip_flag=0.
//  MEASURE: on in_tick peak<=max(peak,mag), win_cnt++. Go DECIDE when win_cnt tick reaches WINDOW,
//   or immediately on a tick with clip (clip_flag=1, window truncated).
//  DECIDE (exactly 1 cycle; any in_tick here is ignored):
//   clip_flag         -> gain=max(gain-ATTACK_STEP,0), quiet=0
//   else peak>=thr_hi -> gain=max(gain-1,0), quiet=0   (thr_hi wins if thr_hi<=thr_lo)
//   else peak<thr_lo  -> quiet++; if quiet==HOLD_WIN: gain=min(gain+1,GAIN_MAX), quiet=0
//   else              -> quiet=0
//   Gain actually changed -> gain_upd=1 next cycle, go SETTLE. Unchanged (incl. saturated at 0/GAIN_MAX)
//   -> no pulse, go MEASURE with new window.
//  Latency: gain valid one CLK after DECIDE, i.e. two CLKs after the triggering in_tick.
//  Reset asserted mid-operation: immediate return to reset values; no partial update visible.
// CONFIGURATION
//  `AUD_AGC_CLIP_CNT_EN defined: clip_cnt port present; increments on each clip tick in SETTLE/MEASURE
//   (AGC modes only), saturates at 16'hFFFF, cleared only by reset.
//  Undefined: no clip_cnt port or counter; all other behaviour identical.
// STRUCTURE
//  aud_agc_defs.vh (shared include): state encodings AGC_MANUAL/SETTLE/MEASURE/DECIDE, abs-saturate function.
//  Sub-module aud_peak_det: mag computation, running max, clip flag; clear input, tick input.
//  Top: FSM, counters, gain arithmetic with clamp.
// TESTING (BITS=16, defaults above, thr_hi=24000, thr_lo=8000)
//  Reset release -> gain=8, agc_state=1; 8 ticks later agc_state=2.
//  64 ticks of +/-30000 -> gain 8->7 with one gain_upd pulse, then 8 discarded ticks before MEASURE.
//  Tick of -32768 at window tick 5 -> DECIDE next cycle, gain 8->6, clip_cnt=1 (macro on).
//  Constant 1000 for 4 full windows -> gain 8->9 only after 4th window; 3 windows + loud window -> no rise.
//  gain=0 and +/-30000 input -> gain stays 0, no gain_upd, MEASURE restarts without SETTLE.
//  agc_en=0, man_gain=40 -> gain=16 next cycle, one pulse; agc_en=1 mid-window -> SETTLE, gain 16 kept.

Source files
------------

// File: rtl/aud_cic_agc_pkg.sv
// Shared definitions for the CIC decimator AGC: FSM state encoding and the
// saturating magnitude helper used by the peak detector.
package aud_cic_agc_pkg;

  typedef enum logic [1:0] {
    AGC_MANUAL  = 2'd0,
    AGC_SETTLE  = 2'd1,
    AGC_MEASURE = 2'd2,
    AGC_DECIDE  = 2'd3
  } agc_state_t;

  // |x| for a sign-extended sample of width bits; -2**(bits-1) clamps to 2**(bits-1)-1
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int unsigned bits);
    logic [31:0] m;
    logic [31:0] lim;
    m   = x[31] ? (~x + 32'd1) : x;
    lim = (32'd1 << (bits - 1)) - 32'd1;
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/aud_cic_agc_peak_det.sv
// Windowed peak detector: saturating magnitude, running max and sticky clip flag.
// Clear has priority over an accumulating tick.
module aud_peak_det
  import aud_cic_agc_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic            i_clr,
  input  logic            i_tick,
  input  logic [BITS-1:0] i_x,
  output logic            o_clip,
  output logic [BITS-2:0] o_peak,
  output logic            o_clip_flag
);

  logic [BITS-2:0] w_mag;
  logic [BITS-2:0] r_peak;
  logic            r_clip_flag;

  assign w_mag       = (BITS-1)'(abs_sat(32'($signed(i_x)), BITS));
  assign o_clip      = (w_mag == '1);
  assign o_peak      = r_peak;
  assign o_clip_flag = r_clip_flag;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_peak      <= '0;
      r_clip_flag <= 1'b0;
    end else if (i_clr) begin
      r_peak      <= '0;
      r_clip_flag <= 1'b0;
    end else if (i_tick) begin
      if (w_mag > r_peak) r_peak <= w_mag;
      if (o_clip) r_clip_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/aud_cic_agc.sv
// AGC for the audio CIC decimator: windowed peak measurement drives the CIC gain code.
// Optional saturating clip counter port enabled by defining AUD_AGC_CLIP_CNT_EN.
module aud_cic_agc
  import aud_cic_agc_pkg::*;
#(
  parameter int unsigned BITS        = 16,
  parameter int unsigned GAIN_BITS   = 8,
  parameter int unsigned GAIN_MAX    = 16,
  parameter int unsigned GAIN_INIT   = 8,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned SETTLE      = 8,
  parameter int unsigned HOLD_WIN    = 4,
  parameter int unsigned ATTACK_STEP = 2
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 agc_en,
  input  logic [GAIN_BITS-1:0] man_gain,
  input  logic [BITS-2:0]      thr_hi,
  input  logic [BITS-2:0]      thr_lo,
  input  logic                 in_tick,
  input  logic [BITS-1:0]      x_in,
  output logic [GAIN_BITS-1:0] gain,
  output logic                 gain_upd,
  output logic [1:0]           agc_state
`ifdef AUD_AGC_CLIP_CNT_EN
  ,
  output logic [15:0]          clip_cnt
`endif
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned WW = $clog2(WINDOW + 1);
  localparam int unsigned QW = $clog2(HOLD_WIN + 1);
  localparam logic [GAIN_BITS-1:0] GMAX  = GAIN_BITS'(GAIN_MAX);
  localparam logic [GAIN_BITS-1:0] GINIT = GAIN_BITS'(GAIN_INIT);
  localparam logic [GAIN_BITS-1:0] GSTEP = GAIN_BITS'(ATTACK_STEP);

  agc_state_t           r_state;
  logic [GAIN_BITS-1:0] r_gain;
  logic                 r_gain_upd;
  logic [SW-1:0]        r_settle_cnt;
  logic [WW-1:0]        r_win_cnt;
  logic [QW-1:0]        r_quiet;

  logic                 w_clip;
  logic                 w_clip_flag;
  logic [BITS-2:0]      w_peak;
  logic [GAIN_BITS-1:0] w_man;
  logic [GAIN_BITS-1:0] w_dec_gain;
  logic [QW-1:0]        w_dec_quiet;

  // Peak is held cleared outside MEASURE, so DECIDE sees the finished window and
  // the window restarts clean whichever way MEASURE is re-entered.
  aud_peak_det #(.BITS(BITS)) u_peak (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .i_clr      (r_state != AGC_MEASURE),
    .i_tick     (in_tick && (r_state == AGC_MEASURE)),
    .i_x        (x_in),
    .o_clip     (w_clip),
    .o_peak     (w_peak),
    .o_clip_flag(w_clip_flag)
  );

  assign w_man     = (man_gain > GMAX) ? GMAX : man_gain;
  assign gain      = r_gain;
  assign gain_upd  = r_gain_upd;
  assign agc_state = r_state;

  always_comb begin
    w_dec_gain  = r_gain;
    w_dec_quiet = '0;
    if (w_clip_flag) begin
      w_dec_gain = (r_gain >= GSTEP) ? r_gain - GSTEP : '0;
    end else if (w_peak >= thr_hi) begin
      w_dec_gain = (r_gain != '0) ? r_gain - GAIN_BITS'(1) : '0;
    end else if (w_peak < thr_lo) begin
      if (r_quiet == QW'(HOLD_WIN - 1))
        w_dec_gain = (r_gain < GMAX) ? r_gain + GAIN_BITS'(1) : GMAX;
      else
        w_dec_quiet = r_quiet + QW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state      <= AGC_SETTLE;
      r_gain       <= GINIT;
      r_gain_upd   <= 1'b0;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_quiet      <= '0;
    end else begin
      r_gain_upd <= 1'b0;
      if (!agc_en) begin
        r_state      <= AGC_MANUAL;
        r_gain       <= w_man;
        r_gain_upd   <= (w_man != r_gain);
        r_settle_cnt <= '0;
        r_win_cnt    <= '0;
        r_quiet      <= '0;
      end else begin
        unique case (r_state)
          AGC_MANUAL: begin
            r_state      <= AGC_SETTLE;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_quiet      <= '0;
          end
          AGC_SETTLE: if (in_tick) begin
            if (r_settle_cnt == SW'(SETTLE - 1)) begin
              r_state      <= AGC_MEASURE;
              r_settle_cnt <= '0;
              r_win_cnt    <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
          AGC_MEASURE: if (in_tick) begin
            if (w_clip || (r_win_cnt == WW'(WINDOW - 1))) begin
              r_state   <= AGC_DECIDE;
              r_win_cnt <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WW'(1);
            end
          end
          AGC_DECIDE: begin
            r_quiet <= w_dec_quiet;
            if (w_dec_gain != r_gain) begin
              r_gain       <= w_dec_gain;
              r_gain_upd   <= 1'b1;
              r_state      <= AGC_SETTLE;
              r_settle_cnt <= '0;
            end else begin
              r_state <= AGC_MEASURE;
            end
          end
          default: r_state <= AGC_SETTLE;
        endcase
      end
    end
  end

`ifdef AUD_AGC_CLIP_CNT_EN
  logic [15:0] r_clip_cnt;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)
      r_clip_cnt <= '0;
    else if (in_tick && w_clip && ((r_state == AGC_SETTLE) || (r_state == AGC_MEASURE)) &&
             (r_clip_cnt != '1))
      r_clip_cnt <= r_clip_cnt + 16'd1;
  end

  assign clip_cnt = r_clip_cnt;
`endif

endmodule

// File: tb/tb_aud_cic_agc.sv
// Bench for aud_cic_agc: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a window-level behavioural model.
module tb_aud_cic_agc;

  logic        CLK      = 1'b0;
  logic        RSTb     = 1'b0;
  logic        agc_en   = 1'b1;
  logic [7:0]  man_gain = '0;
  logic [14:0] thr_hi   = 15'd24000;
  logic [14:0] thr_lo   = 15'd8000;
  logic        in_tick  = 1'b0;
  logic [15:0] x_in     = '0;
  logic [7:0]  gain;
  logic        gain_upd;
  logic [1:0]  agc_state;
`ifdef AUD_AGC_CLIP_CNT_EN
  logic [15:0] clip_cnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_on   = 1'b0;

  always #5 CLK = ~CLK;

  aud_cic_agc #(
    .BITS(16), .GAIN_BITS(8), .GAIN_MAX(16), .GAIN_INIT(8),
    .WINDOW(64), .SETTLE(8), .HOLD_WIN(4), .ATTACK_STEP(2)
  ) dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .agc_en   (agc_en),
    .man_gain (man_gain),
    .thr_hi   (thr_hi),
    .thr_lo   (thr_lo),
    .in_tick  (in_tick),
    .x_in     (x_in),
    .gain     (gain),
    .gain_upd (gain_upd),
    .agc_state(agc_state)
`ifdef AUD_AGC_CLIP_CNT_EN
    ,
    .clip_cnt (clip_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      if (n_errs <= 50)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks the mode, collects the window's magnitudes in a queue and
  // applies the gain rules to the window as a whole when it closes.
  int m_mode = 1, m_gain = 8, m_upd = 0, m_settle = 0, m_quiet = 0, m_clips = 0;
  int m_win[$];
  bit m_clip = 1'b0;
  int xv, mg, pk, ng;

  function automatic int magf(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 32767) ? 32767 : a;
  endfunction

  always @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      m_mode = 1; m_gain = 8; m_upd = 0; m_settle = 0; m_quiet = 0; m_clips = 0;
      m_win.delete(); m_clip = 1'b0;
    end else begin
      m_upd = 0;
      xv = int'($signed(x_in));
      mg = magf(xv);
      if (!agc_en) begin
        ng = (int'(man_gain) > 16) ? 16 : int'(man_gain);
        m_upd  = (ng != m_gain) ? 1 : 0;
        m_gain = ng;
        m_mode = 0; m_settle = 0; m_quiet = 0; m_win.delete(); m_clip = 1'b0;
      end else begin
        case (m_mode)
          0: begin m_mode = 1; m_settle = 0; m_quiet = 0; end
          1: if (in_tick) begin
            if (mg == 32767 && m_clips < 65535) m_clips++;
            m_settle++;
            if (m_settle == 8) begin m_mode = 2; m_win.delete(); m_clip = 1'b0; end
          end
          2: if (in_tick) begin
            if (mg == 32767 && m_clips < 65535) m_clips++;
            m_win.push_back(mg);
            if (mg == 32767) begin m_clip = 1'b1; m_mode = 3; end
            else if (m_win.size() == 64) m_mode = 3;
          end
          default: begin
            pk = 0;
            foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
            ng = m_gain;
            if (m_clip) begin
              ng = (m_gain - 2 < 0) ? 0 : m_gain - 2; m_quiet = 0;
            end else if (pk >= int'(thr_hi)) begin
              ng = (m_gain - 1 < 0) ? 0 : m_gain - 1; m_quiet = 0;
            end else if (pk < int'(thr_lo)) begin
              m_quiet++;
              if (m_quiet == 4) begin ng = (m_gain + 1 > 16) ? 16 : m_gain + 1; m_quiet = 0; end
            end else begin
              m_quiet = 0;
            end
            if (ng != m_gain) begin
              m_gain = ng; m_upd = 1; m_mode = 1; m_settle = 0;
            end else begin
              m_mode = 2;
            end
            m_win.delete(); m_clip = 1'b0;
          end
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("gain", int'(gain), m_gain);
      check("gain_upd", int'(gain_upd), m_upd);
      check("agc_state", int'(agc_state), m_mode);
`ifdef AUD_AGC_CLIP_CNT_EN
      check("clip_cnt", int'(clip_cnt), m_clips);
`endif
    end
  end

  task automatic drive(input bit t, input int v);
    in_tick = t;
    x_in    = 16'(v);
    @(posedge CLK); #1;
  endtask

  task automatic tick(input int v);
    drive(1'b1, v);
    drive(1'b0, 0);
  endtask

  task automatic settle_ticks();
    repeat (8) tick(0);
  endtask

  task automatic window(input int a);
    for (int i = 0; i < 64; i++) tick((i % 2) ? -a : a);
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    repeat (2) drive(1'b0, 0);
    RSTb = 1'b1;
    drive(1'b0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    @(posedge CLK); #1;
    chk_on = 1'b1;

    do_reset();
    check("rst_gain", int'(gain), 8);
    check("rst_state", int'(agc_state), 1);
    check("rst_upd", int'(gain_upd), 0);
    repeat (7) tick(0);
    check("settle7_state", int'(agc_state), 1);
    tick(0);
    check("settle8_state", int'(agc_state), 2);

    window(30000);
    check("loud_gain", int'(gain), 7);
    check("loud_upd", int'(gain_upd), 1);
    check("loud_state", int'(agc_state), 1);
    repeat (7) tick(30000);
    check("loud_settle7", int'(agc_state), 1);
    tick(30000);
    check("loud_settle8", int'(agc_state), 2);
    check("loud_gain_kept", int'(gain), 7);

    do_reset();
    settle_ticks();
    repeat (4) tick(100);
    drive(1'b1, -32768);
    check("clip_decide", int'(agc_state), 3);
    drive(1'b0, 0);
    check("clip_gain", int'(gain), 6);
    check("clip_upd", int'(gain_upd), 1);
    check("clip_state", int'(agc_state), 1);
`ifdef AUD_AGC_CLIP_CNT_EN
    check("clip_cnt_lit", int'(clip_cnt), 1);
`endif

    do_reset();
    settle_ticks();
    repeat (3) window(1000);
    check("quiet3_gain", int'(gain), 8);
    check("quiet3_state", int'(agc_state), 2);
    window(1000);
    check("quiet4_gain", int'(gain), 9);
    check("quiet4_upd", int'(gain_upd), 1);

    do_reset();
    settle_ticks();
    repeat (3) window(1000);
    window(16000);
    window(1000);
    check("quiet_broken_gain", int'(gain), 8);
    check("quiet_broken_state", int'(agc_state), 2);

    agc_en = 1'b0; man_gain = 8'd0;
    drive(1'b0, 0);
    check("man0_gain", int'(gain), 0);
    check("man0_upd", int'(gain_upd), 1);
    check("man0_state", int'(agc_state), 0);
    agc_en = 1'b1;
    drive(1'b0, 0);
    check("man0_exit_state", int'(agc_state), 1);
    settle_ticks();
    window(30000);
    check("floor_gain", int'(gain), 0);
    check("floor_upd", int'(gain_upd), 0);
    check("floor_state", int'(agc_state), 2);

    agc_en = 1'b0; man_gain = 8'd40;
    drive(1'b0, 0);
    check("man40_gain", int'(gain), 16);
    check("man40_upd", int'(gain_upd), 1);
    check("man40_state", int'(agc_state), 0);
    drive(1'b0, 0);
    check("man40_upd_once", int'(gain_upd), 0);
    agc_en = 1'b1;
    drive(1'b0, 0);
    settle_ticks();
    repeat (10) tick(1000);
    check("midwin_state", int'(agc_state), 2);
    agc_en = 1'b0;
    drive(1'b0, 0);
    check("midwin_man_state", int'(agc_state), 0);
    check("midwin_man_upd", int'(gain_upd), 0);
    agc_en = 1'b1;
    drive(1'b0, 0);
    check("midwin_resettle", int'(agc_state), 1);
    check("midwin_gain", int'(gain), 16);

    for (int s = 0; s < 40; s++) begin
      int cls;
      int len;
      cls = $urandom_range(0, 9);
      len = $urandom_range(100, 1500);
      if ($urandom_range(0, 9) == 0) begin thr_hi = 15'd5000;  thr_lo = 15'd20000; end
      else                           begin thr_hi = 15'd24000; thr_lo = 15'd8000;  end
      agc_en = (cls != 9);
      if (s == 20) begin
        #3 RSTb = 1'b0;
        drive(1'b0, 0);
        check("rst_mid_gain", int'(gain), 8);
        check("rst_mid_state", int'(agc_state), 1);
        RSTb = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        int a;
        int v;
        bit neg;
        if (cls == 9 && $urandom_range(0, 3) == 0) man_gain = 8'($urandom_range(0, 40));
        neg = $urandom_range(0, 1);
        if (cls <= 3)      a = $urandom_range(0, 7999);
        else if (cls <= 5) a = $urandom_range(8000, 23999);
        else if (cls <= 7) a = $urandom_range(24000, 32766);
        else               a = ($urandom_range(0, 7) == 0) ? 32767 : $urandom_range(24000, 32766);
        v = neg ? -a : a;
        if (cls == 8 && a == 32767 && neg) v = -32768;
        drive(1'($urandom_range(0, 1)), v);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
